// File: rtl/mux_rr_pkg.sv
// mux_rr_pkg: shared defaults and mode encodings for the round-robin mux
package mux_rr_pkg;
  localparam int N_DEF = 4;
  localparam int W_DEF = 8;
  localparam int CW_DEF = 16;
  localparam logic MODE_FIXED = 1'b0;
  localparam logic MODE_RR = 1'b1;
endpackage

// File: rtl/rr_arbiter.sv
// rr_arbiter: combinational fixed-select / round-robin grant search
module rr_arbiter import mux_rr_pkg::*; #(
  parameter int N = N_DEF
) (
  input  logic [N-1:0]         req,
  input  logic [$clog2(N)-1:0] ptr,
  input  logic                 mode,
  input  logic [$clog2(N)-1:0] sel,
  output logic                 gnt_valid,
  output logic [$clog2(N)-1:0] gnt_idx
);
  localparam int SW = $clog2(N);
  always_comb begin
    gnt_valid = 1'b0;
    gnt_idx = '0;
    if (mode == MODE_FIXED) begin
      for (int i = 0; i < N; i++)
        if (sel == SW'(i) && req[i]) begin
          gnt_valid = 1'b1;
          gnt_idx = SW'(i);
        end
    end else begin
      // walk backwards so the channel closest to ptr wins last
      for (int k = N - 1; k >= 0; k--)
        if (req[(int'(ptr) + k) % N]) begin
          gnt_valid = 1'b1;
          gnt_idx = SW'((int'(ptr) + k) % N);
        end
    end
  end
endmodule

// File: rtl/mux_rr.sv
// mux_rr: N-channel mux with fixed/round-robin arbitration into a one-deep output register
module mux_rr import mux_rr_pkg::*; #(
  parameter int N = N_DEF,
  parameter int W = W_DEF,
  parameter int CW = CW_DEF
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 mode,
  input  logic [$clog2(N)-1:0] sel,
  input  logic [N-1:0]         in_valid,
  input  logic [N*W-1:0]       in_data,
  output logic [N-1:0]         in_ready,
  output logic                 out_valid,
  output logic [W-1:0]         out_data,
  output logic [$clog2(N)-1:0] out_ch,
  input  logic                 out_ready,
  output logic [CW-1:0]        xfer_cnt
);
  localparam int SW = $clog2(N);
  logic [SW-1:0] ptr;
  logic [SW-1:0] gnt_idx;
  logic gnt_valid;
  logic load;
  rr_arbiter #(.N(N)) u_arb (
    .req(in_valid),
    .ptr(ptr),
    .mode(mode),
    .sel(sel),
    .gnt_valid(gnt_valid),
    .gnt_idx(gnt_idx)
  );
  // rst_n gating keeps in_ready low throughout reset
  assign load = rst_n && gnt_valid && (!out_valid || out_ready);
  assign in_ready = load ? N'(1) << gnt_idx : '0;
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      out_valid <= 1'b0;
      out_data <= '0;
      out_ch <= '0;
      ptr <= '0;
      xfer_cnt <= '0;
    end else if (load) begin
      out_valid <= 1'b1;
      out_data <= in_data[gnt_idx*W +: W];
      out_ch <= gnt_idx;
      xfer_cnt <= xfer_cnt + 1'b1;
      if (mode == MODE_RR) ptr <= (gnt_idx == SW'(N - 1)) ? '0 : gnt_idx + 1'b1;
    end else if (out_ready) begin
      out_valid <= 1'b0;
    end
  end
endmodule

// File: tb/tb_mux_rr.sv
// tb_mux_rr: table-driven and scoreboard checks of mux_rr (N=4, CW=4) plus an N=3 instance
module tb_mux_rr;
  typedef struct {
    logic mode;
    logic [1:0] sel;
    logic [3:0] iv;
    logic ordy;
    logic [31:0] dat;
    logic [3:0] rdy;
    logic vld;
    logic [1:0] ch;
  } vec_t;
  typedef struct {
    logic [1:0] ch;
    logic [7:0] data;
  } exp_t;
  logic clk = 1'b0;
  logic rst_n;
  logic mode = 1'b0;
  logic [1:0] sel = '0;
  logic [3:0] iv = '0;
  logic [31:0] din = '0;
  logic [3:0] rdy;
  logic ov;
  logic [7:0] od;
  logic [1:0] oc;
  logic ordy = 1'b0;
  logic [3:0] cnt;
  logic mode3 = 1'b0;
  logic [1:0] sel3 = 2'd3;
  logic [2:0] iv3 = 3'b111;
  logic [23:0] d3 = 24'hC0B0A0;
  logic [2:0] rdy3;
  logic ov3;
  logic [7:0] od3;
  logic [1:0] oc3;
  logic ordy3 = 1'b1;
  logic [3:0] cnt3;
  int nvec = 0;
  int nerr = 0;
  int mptr = 0;
  int mcnt = 0;
  logic mvalid = 1'b0;
  exp_t q[$];
  vec_t tv[$];
  logic [3:0] got_rdy;
  always #5 clk = ~clk;
  mux_rr #(.N(4), .W(8), .CW(4)) dut (
    .clk(clk), .rst_n(rst_n), .mode(mode), .sel(sel), .in_valid(iv), .in_data(din),
    .in_ready(rdy), .out_valid(ov), .out_data(od), .out_ch(oc), .out_ready(ordy), .xfer_cnt(cnt)
  );
  mux_rr #(.N(3), .W(8), .CW(4)) u3 (
    .clk(clk), .rst_n(rst_n), .mode(mode3), .sel(sel3), .in_valid(iv3), .in_data(d3),
    .in_ready(rdy3), .out_valid(ov3), .out_data(od3), .out_ch(oc3), .out_ready(ordy3), .xfer_cnt(cnt3)
  );
  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    nvec++;
    if (act !== exp) begin
      nerr++;
      $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
    end
  endtask
  function automatic int mgrant(input logic m, input logic [1:0] s, input logic [3:0] v, input int p);
    if (!m) return v[s] ? int'(s) : -1;
    for (int k = 0; k < 4; k++)
      if (v[(p + k) % 4]) return (p + k) % 4;
    return -1;
  endfunction
  // enters and leaves at posedge+1; scoreboard pushes on predicted load, pops on handshake
  task automatic cyc(input logic m, input logic [1:0] s, input logic [3:0] v, input logic r, input logic [31:0] d);
    int g;
    logic ld;
    mode = m; sel = s; iv = v; ordy = r; din = d;
    #1;
    g = mgrant(m, s, v, mptr);
    ld = (g >= 0) && (!mvalid || r);
    got_rdy = rdy;
    chk("in_ready", rdy, ld ? 32'(1 << g) : 0);
    if (mvalid && r && q.size() > 0) void'(q.pop_front());
    if (ld) q.push_back('{ch: 2'(g), data: d[g*8 +: 8]});
    @(posedge clk);
    #1;
    mvalid = ld ? 1'b1 : (r ? 1'b0 : mvalid);
    if (ld) begin
      mcnt = (mcnt + 1) % 16;
      if (m) mptr = (g + 1) % 4;
    end
    chk("out_valid", ov, mvalid);
    chk("xfer_cnt", cnt, mcnt);
    if (mvalid) begin
      if (q.size() == 0) chk("scoreboard_empty", 1, 0);
      else begin
        chk("out_ch", oc, q[0].ch);
        chk("out_data", od, q[0].data);
      end
    end
  endtask
  initial begin
    for (int i = 0; i < 8; i++)
      tv.push_back('{1'b1, 2'd0, 4'hF, 1'b1, 32'h1 * $urandom, 4'(1 << (i % 4)), 1'b1, 2'(i % 4)});
    tv.push_back('{1'b1, 2'd0, 4'hA, 1'b1, 32'h44332211, 4'h2, 1'b1, 2'd1});
    tv.push_back('{1'b1, 2'd0, 4'hA, 1'b1, 32'h88776655, 4'h8, 1'b1, 2'd3});
    tv.push_back('{1'b1, 2'd0, 4'hA, 1'b1, 32'hCCBBAA99, 4'h2, 1'b1, 2'd1});
    tv.push_back('{1'b0, 2'd2, 4'h4, 1'b1, 32'h33A52211, 4'h4, 1'b1, 2'd2});
    for (int i = 0; i < 3; i++)
      tv.push_back('{1'b0, 2'd2, 4'h4, 1'b0, 32'h77665544, 4'h0, 1'b1, 2'd2});
    tv.push_back('{1'b0, 2'd2, 4'h0, 1'b1, 32'h0, 4'h0, 1'b0, 2'd0});
    tv.push_back('{1'b1, 2'd0, 4'hF, 1'b1, 32'h5A6B7C8D, 4'h4, 1'b1, 2'd2});
    tv.push_back('{1'b0, 2'd1, 4'hD, 1'b1, 32'h01020304, 4'h0, 1'b0, 2'd0});
    for (int i = 0; i < 4; i++)
      tv.push_back('{1'b1, 2'd0, 4'hF, 1'b1, 32'h1 * $urandom, 4'(1 << ((i + 3) % 4)), 1'b1, 2'((i + 3) % 4)});
    rst_n = 1'b0;
    mode = 1'b1; iv = 4'hF; ordy = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    chk("rst_out_valid", ov, 0);
    chk("rst_out_data", od, 0);
    chk("rst_out_ch", oc, 0);
    chk("rst_xfer_cnt", cnt, 0);
    chk("rst_in_ready", rdy, 0);
    rst_n = 1'b1;
    foreach (tv[i]) begin
      cyc(tv[i].mode, tv[i].sel, tv[i].iv, tv[i].ordy, tv[i].dat);
      chk("tab_in_ready", got_rdy, tv[i].rdy);
      chk("tab_out_valid", ov, tv[i].vld);
      if (tv[i].vld) chk("tab_out_ch", oc, tv[i].ch);
      if (i == 7) chk("cnt_after_8", cnt, 8);
      if (i == 12) chk("held_a5", od, 8'hA5);
      if (i == 21) chk("cnt_wrap_17", cnt, 1);
    end
    for (int i = 0; i < 3; i++) begin
      cyc(1'b1, 2'd0, 4'h0, 1'b1, 32'h0);
      chk("n3_in_ready_none", rdy3, 0);
      chk("n3_out_valid_none", ov3, 0);
    end
    sel3 = 2'd2;
    cyc(1'b1, 2'd0, 4'h0, 1'b1, 32'h0);
    chk("n3_out_valid", ov3, 1);
    chk("n3_out_ch", oc3, 2);
    chk("n3_out_data", od3, 8'hC0);
    chk("n3_in_ready", rdy3, 3'b100);
    sel3 = 2'd3;
    cyc(1'b1, 2'd0, 4'h0, 1'b1, 32'h0);
    chk("n3_out_valid_clear", ov3, 0);
    chk("n3_in_ready_clear", rdy3, 0);
    cyc(1'b1, 2'd0, 4'hF, 1'b0, 32'hDEADBEEF);
    cyc(1'b1, 2'd0, 4'hF, 1'b0, 32'hDEADBEEF);
    chk("pre_rst_valid", ov, 1);
    #2 rst_n = 1'b0;
    #1;
    chk("async_out_valid", ov, 0);
    chk("async_xfer_cnt", cnt, 0);
    chk("async_out_data", od, 0);
    chk("async_in_ready", rdy, 0);
    @(posedge clk);
    #1;
    chk("rst_hold_valid", ov, 0);
    rst_n = 1'b1;
    mptr = 0; mcnt = 0; mvalid = 1'b0; q.delete();
    cyc(1'b1, 2'd0, 4'hF, 1'b1, 32'h13579BDF);
    chk("resume_ch0", oc, 0);
    cyc(1'b1, 2'd0, 4'hF, 1'b1, 32'h2468ACE0);
    chk("resume_ch1", oc, 1);
    chk("resume_cnt", cnt, 2);
    $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
    $finish;
  end
endmodule
